sync_lock_ctrl: RTL and testbench
=================================

// Module: sync_lock_ctrl
// PURPOSE
//  Sequences a bank of N_SEEKERS header seekers that each scan a disjoint subset of the
//  67-bit gearbox slice positions. Resets the bank, waits for a seeker to report sync,
//  and picks the winner by fixed priority. Publishes the lock offset, then monitors
//  aligned 2-bit headers for loss of lock and re-runs the search on errors or timeout.
//  Sits between the seeker bank and the frame aligner/descrambler in the RX path.
// PARAMETERS
//  N_SEEKERS      4     number of seeker instances (1..8)
//  RST_CYCLES     2     cycles seeker_rst_o is held high per search restart (>=1)
//  SEARCH_TMO     1024  buffer_dv_i strobes allowed in SEARCH before restart (>=1)
//  WIN_LEN        64    headers per error-monitoring window (>=1)
//  ERR_MAX        8     invalid headers within one window that declare loss of lock (1..WIN_LEN)
// PORTS
//  clk_i            in   1            system clock
//  rst_i            in   1            asynchronous reset, active high
//  force_resync_i   in   1            request an immediate restart of the search
//  buffer_dv_i      in   1            gearbox slice valid strobe, same as seeker bank
//  seeker_synced_i  in   N_SEEKERS    per-seeker is_synced
//  seeker_offset_i  in   7*N_SEEKERS  per-seeker offset_pos; seeker k at [7k+6:7k]
//  hdr_i            in   2            header at locked offset from downstream extractor
//  hdr_vld_i        in   1            hdr_i qualifier
//  seeker_rst_o     out  1            synchronous reset to seeker bank
//  locked_o         out  1            high while in LOCKED
//  offset_o         out  7            locked header offset, valid when locked_o
//  winner_o         out  3            index of winning seeker, valid when locked_o
//  lock_lost_o      out  1            one-cycle pulse on loss of lock or timeout
// BEHAVIOUR
//  - Valid header: hdr_i == 2'b01 (data) or 2'b10 (cmd). 2'b00 and 2'b11 are invalid.
//  - Reset values: state=RESTART, seeker_rst_o=1, locked_o=0, offset_o=0, winner_o=0,
//    lock_lost_o=0, and all counters 0.
//  - RESTART: seeker_rst_o=1 for exactly RST_CYCLES cycles, then go to SEARCH.
//    Entering RESTART from LOCKED or SEARCH reloads the cycle count.
//  - SEARCH: seeker_rst_o=0. Each buffer_dv_i increments tmo_cnt.
//    - If any seeker_synced_i bit is 1 in a cycle with buffer_dv_i=1: take the lowest set
//      index k. Next cycle: winner_o=k, offset_o=seeker_offset_i[k], locked_o=1,
//      state=LOCKED, err/window counters cleared.
//    - Else if tmo_cnt reaches SEARCH_TMO: lock_lost_o pulses, state=RESTART.
//    - A sync seen on the same strobe that hits the timeout wins; lock is taken.
//  - LOCKED: each hdr_vld_i increments win_cnt. An invalid header also increments err_cnt.
//    - If err_cnt, including the current header, reaches ERR_MAX: next cycle
//      lock_lost_o=1, locked_o=0, state=RESTART.
//    - Else if win_cnt reaches WIN_LEN: clear win_cnt and err_cnt (window rollover).
//    - Loss of lock takes precedence over a rollover in the same cycle.
//    - offset_o and winner_o stay frozen in LOCKED. seeker_synced_i is ignored in LOCKED,
//      so a seeker dropping sync does not unlock.
//  - force_resync_i=1 in any state: next state RESTART, locked_o=0, and no lock_lost_o.
//    It has priority over every other transition. Holding it high keeps the block in
//    RESTART with seeker_rst_o=1.
//  - hdr_vld_i outside LOCKED is ignored. buffer_dv_i outside SEARCH is ignored.
//  - Latency: seeker sync strobe to locked_o = 1 cycle. Header that hits ERR_MAX to
//    lock_lost_o = 1 cycle.
//  - Counters saturate and never wrap. Widths: $clog2(param+1).
//  - Asynchronous reset mid-operation returns all state to reset values immediately.
// CONFIGURATION
//  - SYNC_LOCK_CTRL_STATS_EN defined: adds out ports lock_loss_cnt_o[15:0] and
//    tmo_cnt_o[15:0].
//    - lock_loss_cnt_o counts LOCKED->RESTART transitions caused by errors.
//    - tmo_cnt_o counts SEARCH timeouts.
//    - Both saturate at 16'hFFFF and are cleared only by rst_i.
//  - Not defined: those ports and their counters do not exist.
//  - All other behaviour is identical with or without the macro.
// TESTING
//  - Reset release with RST_CYCLES=2 -> seeker_rst_o high 2 cycles after reset, then low,
//    and state is SEARCH.
//  - seeker_synced_i=4'b0110 with offsets 5 and 37 at seekers 1 and 2, strobe ->
//    next cycle locked_o=1, winner_o=1, offset_o=5.
//  - No sync for 1024 strobes -> lock_lost_o single pulse, then seeker_rst_o high 2 cycles.
//  - LOCKED with 7 bad headers, then rollover at 64, then 7 more -> stays locked.
//    8 bad within one window -> unlocks 1 cycle after the 8th.
//  - 8th bad header is the 64th of its window -> loss of lock wins, RESTART entered.
//  - force_resync_i pulse while LOCKED -> locked_o=0 next cycle, no lock_lost_o.
//    With stats enabled, lock_loss_cnt_o is unchanged.

Source files
------------

// File: rtl/sync_lock_ctrl_if.sv
// sync_lock_ctrl_if: seeker-bank and header-monitor signals of sync_lock_ctrl; SYNC_LOCK_CTRL_STATS_EN adds stats outputs
interface sync_lock_ctrl_if #(
  parameter int N_SEEKERS = 4
);
  logic                   force_resync_i;
  logic                   buffer_dv_i;
  logic [N_SEEKERS-1:0]   seeker_synced_i;
  logic [7*N_SEEKERS-1:0] seeker_offset_i;
  logic [1:0]             hdr_i;
  logic                   hdr_vld_i;
  logic                   seeker_rst_o;
  logic                   locked_o;
  logic [6:0]             offset_o;
  logic [2:0]             winner_o;
  logic                   lock_lost_o;
`ifdef SYNC_LOCK_CTRL_STATS_EN
  logic [15:0]            lock_loss_cnt_o;
  logic [15:0]            tmo_cnt_o;
`endif
  // master is the RX path environment, slave is the controller
  modport master (
    output force_resync_i, buffer_dv_i, seeker_synced_i, seeker_offset_i, hdr_i, hdr_vld_i,
`ifdef SYNC_LOCK_CTRL_STATS_EN
    input  lock_loss_cnt_o, tmo_cnt_o,
`endif
    input  seeker_rst_o, locked_o, offset_o, winner_o, lock_lost_o
  );
  modport slave (
    input  force_resync_i, buffer_dv_i, seeker_synced_i, seeker_offset_i, hdr_i, hdr_vld_i,
`ifdef SYNC_LOCK_CTRL_STATS_EN
    output lock_loss_cnt_o, tmo_cnt_o,
`endif
    output seeker_rst_o, locked_o, offset_o, winner_o, lock_lost_o
  );
endinterface

// File: rtl/sync_lock_ctrl.sv
// sync_lock_ctrl: header-seeker bank sequencer and loss-of-lock monitor; SYNC_LOCK_CTRL_STATS_EN adds loss/timeout counters
module sync_lock_ctrl #(
  parameter int N_SEEKERS  = 4,
  parameter int RST_CYCLES = 2,
  parameter int SEARCH_TMO = 1024,
  parameter int WIN_LEN    = 64,
  parameter int ERR_MAX    = 8
) (
  input logic clk_i,
  input logic rst_i,
  sync_lock_ctrl_if.slave bus
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(SEARCH_TMO + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  typedef enum logic [1:0] {RESTART, SEARCH, LOCKED} state_t;
  state_t state, state_nxt;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;
  logic [2:0] pick;
  logic [6:0] pick_off;
  logic [6:0] offset;
  logic [2:0] winner;
  logic lock_lost;
  logic frc, bad, rst_done, take, tmo_hit, err_hit, roll;
  assign frc      = bus.force_resync_i;
  assign bad      = ~^bus.hdr_i;
  assign rst_done = rst_cnt >= RW'(RST_CYCLES - 1);
  assign take     = state == SEARCH && bus.buffer_dv_i && |bus.seeker_synced_i;
  assign tmo_hit  = state == SEARCH && bus.buffer_dv_i && !take && tmo_cnt >= TW'(SEARCH_TMO - 1);
  assign err_hit  = state == LOCKED && bus.hdr_vld_i && bad && err_cnt >= EW'(ERR_MAX - 1);
  assign roll     = state == LOCKED && bus.hdr_vld_i && win_cnt >= WW'(WIN_LEN - 1);
  // lowest set index wins; scanning downward lets the lowest overwrite the rest
  always_comb begin
    pick = '0;
    pick_off = '0;
    for (int k = N_SEEKERS - 1; k >= 0; k--)
      if (bus.seeker_synced_i[k]) begin
        pick = 3'(k);
        pick_off = bus.seeker_offset_i[7*k +: 7];
      end
  end
  // force beats everything, a sync on the timeout strobe beats the timeout
  always_comb begin
    state_nxt = frc ? RESTART :
                (state == RESTART && rst_done) ? SEARCH :
                take ? LOCKED :
                (tmo_hit || err_hit) ? RESTART : state;
  end
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= RESTART;
    else state <= state_nxt;
  // counters are cleared whenever their state is left or forced, so every entry starts fresh
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rst_cnt <= '0;
      tmo_cnt <= '0;
      win_cnt <= '0;
      err_cnt <= '0;
      offset <= '0;
      winner <= '0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= !frc && (tmo_hit || err_hit);
      rst_cnt <= (state == RESTART && !frc && !rst_done) ? rst_cnt + 1'b1 : '0;
      tmo_cnt <= (state != SEARCH || frc || take || tmo_hit) ? '0 :
                 (bus.buffer_dv_i && tmo_cnt != TW'(SEARCH_TMO)) ? tmo_cnt + 1'b1 : tmo_cnt;
      win_cnt <= (state != LOCKED || frc || err_hit || roll) ? '0 :
                 (bus.hdr_vld_i && win_cnt != WW'(WIN_LEN)) ? win_cnt + 1'b1 : win_cnt;
      err_cnt <= (state != LOCKED || frc || err_hit || roll) ? '0 :
                 (bus.hdr_vld_i && bad && err_cnt != EW'(ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;
      if (take && !frc) begin
        offset <= pick_off;
        winner <= pick;
      end
    end
  assign bus.seeker_rst_o = state == RESTART;
  assign bus.locked_o     = state == LOCKED;
  assign bus.offset_o     = offset;
  assign bus.winner_o     = winner;
  assign bus.lock_lost_o  = lock_lost;
`ifdef SYNC_LOCK_CTRL_STATS_EN
  logic [15:0] loss_cnt, tmo_evt_cnt;
  // saturating event counters, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      loss_cnt <= '0;
      tmo_evt_cnt <= '0;
    end else begin
      if (err_hit && !frc && loss_cnt != 16'hFFFF) loss_cnt <= loss_cnt + 1'b1;
      if (tmo_hit && !frc && tmo_evt_cnt != 16'hFFFF) tmo_evt_cnt <= tmo_evt_cnt + 1'b1;
    end
  assign bus.lock_loss_cnt_o = loss_cnt;
  assign bus.tmo_cnt_o       = tmo_evt_cnt;
`endif
endmodule

// File: tb/tb_sync_lock_ctrl.sv
// tb_sync_lock_ctrl: directed self-checking bench for sync_lock_ctrl
module tb_sync_lock_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  sync_lock_ctrl_if #(.N_SEEKERS(4)) bus();
  sync_lock_ctrl #(.N_SEEKERS(4), .RST_CYCLES(2), .SEARCH_TMO(1024), .WIN_LEN(64), .ERR_MAX(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_hdr(input logic [1:0] h);
    bus.hdr_i = h;
    bus.hdr_vld_i = 1'b1;
    step();
    bus.hdr_vld_i = 1'b0;
  endtask
  task automatic wait_search();
    int n = 0;
    while (bus.seeker_rst_o && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (bus.seeker_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL wait_search seeker_rst got=%b exp=0", bus.seeker_rst_o);
    end
  endtask
  task automatic lock_on(input logic [3:0] syn);
    bus.seeker_synced_i = syn;
    bus.buffer_dv_i = 1'b1;
    step();
    bus.seeker_synced_i = '0;
    bus.buffer_dv_i = 1'b0;
  endtask
  task automatic test_reset();
    bus.force_resync_i = 0;
    bus.buffer_dv_i = 0;
    bus.seeker_synced_i = '0;
    bus.seeker_offset_i = {7'd90, 7'd37, 7'd5, 7'd12};
    bus.hdr_i = 2'b00;
    bus.hdr_vld_i = 0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.seeker_rst_o, bus.locked_o, bus.offset_o, bus.winner_o, bus.lock_lost_o} !== {1'b1, 1'b0, 7'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got rst=%b lk=%b off=%0d win=%0d lost=%b exp 1 0 0 0 0",
               bus.seeker_rst_o, bus.locked_o, bus.offset_o, bus.winner_o, bus.lock_lost_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_rst_cycle2 got=%b exp=1", bus.seeker_rst_o);
    end
    step();
    checks++;
    if (bus.seeker_rst_o !== 1'b0 || bus.locked_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_to_search got rst=%b lk=%b exp 0 0", bus.seeker_rst_o, bus.locked_o);
    end
  endtask
  task automatic test_lock();
    bus.seeker_synced_i = 4'b0110;
    step();
    checks++;
    if (bus.locked_o !== 1'b0) begin
      failures++;
      $display("FAIL lock_needs_strobe got=%b exp=0", bus.locked_o);
    end
    lock_on(4'b0110);
    checks++;
    if ({bus.locked_o, bus.winner_o, bus.offset_o, bus.lock_lost_o} !== {1'b1, 3'd1, 7'd5, 1'b0}) begin
      failures++;
      $display("FAIL lock_pick got lk=%b win=%0d off=%0d lost=%b exp 1 1 5 0",
               bus.locked_o, bus.winner_o, bus.offset_o, bus.lock_lost_o);
    end
    lock_on(4'b1111);
    checks++;
    if ({bus.locked_o, bus.winner_o, bus.offset_o} !== {1'b1, 3'd1, 7'd5}) begin
      failures++;
      $display("FAIL lock_frozen got lk=%b win=%0d off=%0d exp 1 1 5", bus.locked_o, bus.winner_o, bus.offset_o);
    end
  endtask
  task automatic test_window();
    for (int i = 0; i < 7; i++) send_hdr(i[0] ? 2'b11 : 2'b00);
    for (int i = 0; i < 57; i++) send_hdr(i[0] ? 2'b10 : 2'b01);
    checks++;
    if (bus.locked_o !== 1'b1 || bus.lock_lost_o !== 1'b0) begin
      failures++;
      $display("FAIL window_7bad got lk=%b lost=%b exp 1 0", bus.locked_o, bus.lock_lost_o);
    end
    for (int i = 0; i < 7; i++) send_hdr(2'b11);
    bus.hdr_i = 2'b00;
    repeat (20) step();
    checks++;
    if (bus.locked_o !== 1'b1) begin
      failures++;
      $display("FAIL window_rollover got lk=%b exp=1", bus.locked_o);
    end
    send_hdr(2'b00);
    checks++;
    if ({bus.lock_lost_o, bus.locked_o, bus.seeker_rst_o} !== 3'b101) begin
      failures++;
      $display("FAIL window_8th got lost=%b lk=%b rst=%b exp 1 0 1", bus.lock_lost_o, bus.locked_o, bus.seeker_rst_o);
    end
    step();
    checks++;
    if (bus.lock_lost_o !== 1'b0 || bus.seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL window_pulse got lost=%b rst=%b exp 0 1", bus.lock_lost_o, bus.seeker_rst_o);
    end
  endtask
  task automatic test_tie_loss();
    wait_search();
    lock_on(4'b0100);
    checks++;
    if ({bus.locked_o, bus.winner_o, bus.offset_o} !== {1'b1, 3'd2, 7'd37}) begin
      failures++;
      $display("FAIL tie_relock got lk=%b win=%0d off=%0d exp 1 2 37", bus.locked_o, bus.winner_o, bus.offset_o);
    end
    for (int i = 0; i < 56; i++) send_hdr(2'b01);
    for (int i = 0; i < 7; i++) send_hdr(2'b11);
    checks++;
    if (bus.locked_o !== 1'b1) begin
      failures++;
      $display("FAIL tie_63 got lk=%b exp=1", bus.locked_o);
    end
    send_hdr(2'b00);
    checks++;
    if ({bus.lock_lost_o, bus.locked_o, bus.seeker_rst_o} !== 3'b101) begin
      failures++;
      $display("FAIL tie_loss_wins got lost=%b lk=%b rst=%b exp 1 0 1", bus.lock_lost_o, bus.locked_o, bus.seeker_rst_o);
    end
`ifdef SYNC_LOCK_CTRL_STATS_EN
    checks++;
    if (bus.lock_loss_cnt_o !== 16'd2) begin
      failures++;
      $display("FAIL stats_loss got=%0d exp=2", bus.lock_loss_cnt_o);
    end
`endif
  endtask
  task automatic test_timeout();
    logic seen = 1'b0;
    wait_search();
    bus.buffer_dv_i = 1'b1;
    repeat (1023) begin
      step();
      seen |= bus.lock_lost_o | bus.locked_o | bus.seeker_rst_o;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early got=%b exp=0", seen);
    end
    step();
    bus.buffer_dv_i = 1'b0;
    checks++;
    if (bus.lock_lost_o !== 1'b1 || bus.seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_hit got lost=%b rst=%b exp 1 1", bus.lock_lost_o, bus.seeker_rst_o);
    end
    step();
    checks++;
    if (bus.lock_lost_o !== 1'b0 || bus.seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_pulse got lost=%b rst=%b exp 0 1", bus.lock_lost_o, bus.seeker_rst_o);
    end
    step();
    checks++;
    if (bus.seeker_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL tmo_rst_len got=%b exp=0", bus.seeker_rst_o);
    end
`ifdef SYNC_LOCK_CTRL_STATS_EN
    checks++;
    if (bus.tmo_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL stats_tmo got=%0d exp=1", bus.tmo_cnt_o);
    end
`endif
  endtask
  task automatic test_tmo_tie();
    bus.buffer_dv_i = 1'b1;
    repeat (1023) step();
    lock_on(4'b1000);
    checks++;
    if ({bus.locked_o, bus.winner_o, bus.offset_o, bus.lock_lost_o} !== {1'b1, 3'd3, 7'd90, 1'b0}) begin
      failures++;
      $display("FAIL tmo_tie got lk=%b win=%0d off=%0d lost=%b exp 1 3 90 0",
               bus.locked_o, bus.winner_o, bus.offset_o, bus.lock_lost_o);
    end
  endtask
  task automatic test_force();
    bus.force_resync_i = 1'b1;
    step();
    bus.force_resync_i = 1'b0;
    checks++;
    if ({bus.locked_o, bus.lock_lost_o, bus.seeker_rst_o} !== 3'b001) begin
      failures++;
      $display("FAIL force_locked got lk=%b lost=%b rst=%b exp 0 0 1", bus.locked_o, bus.lock_lost_o, bus.seeker_rst_o);
    end
`ifdef SYNC_LOCK_CTRL_STATS_EN
    checks++;
    if (bus.lock_loss_cnt_o !== 16'd2) begin
      failures++;
      $display("FAIL force_stats got=%0d exp=2", bus.lock_loss_cnt_o);
    end
`endif
    wait_search();
    bus.force_resync_i = 1'b1;
    lock_on(4'b0001);
    checks++;
    if (bus.locked_o !== 1'b0 || bus.seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL force_beats_sync got lk=%b rst=%b exp 0 1", bus.locked_o, bus.seeker_rst_o);
    end
    repeat (4) step();
    checks++;
    if (bus.seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL force_hold got=%b exp=1", bus.seeker_rst_o);
    end
    bus.force_resync_i = 1'b0;
    step();
    checks++;
    if (bus.seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL force_release got=%b exp=1", bus.seeker_rst_o);
    end
    step();
    checks++;
    if (bus.seeker_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL force_search got=%b exp=0", bus.seeker_rst_o);
    end
  endtask
  task automatic test_async_reset();
    lock_on(4'b0001);
    checks++;
    if ({bus.locked_o, bus.winner_o, bus.offset_o} !== {1'b1, 3'd0, 7'd12}) begin
      failures++;
      $display("FAIL ares_lock got lk=%b win=%0d off=%0d exp 1 0 12", bus.locked_o, bus.winner_o, bus.offset_o);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus.seeker_rst_o, bus.locked_o, bus.offset_o, bus.winner_o, bus.lock_lost_o} !== {1'b1, 1'b0, 7'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL ares_values got rst=%b lk=%b off=%0d win=%0d lost=%b exp 1 0 0 0 0",
               bus.seeker_rst_o, bus.locked_o, bus.offset_o, bus.winner_o, bus.lock_lost_o);
    end
    step();
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_lock();
    test_window();
    test_tie_loss();
    test_timeout();
    test_tmo_tie();
    test_force();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
